// File: rtl/seq101_frame_scanner.sv
// Framed word serialiser feeding an overlapping "101" Moore detector, with a per-frame saturating match count.
// Optional SEQ101_FRAME_RESYNC_EN: clears the detector on each result handshake so no pattern spans frames.
module seq101_frame_scanner #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             det_pulse,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready
);

  localparam int              BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctl_t;
  typedef enum logic [1:0] {D0, D1, D2, D3} det_t;

  ctl_t             ctl_q, ctl_d;
  det_t             det_q, det_d, det_step;
  logic [W-1:0]     sreg_q, sreg_d;
  logic             last_q, last_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q;
  logic             match;

  function automatic det_t det_next(input det_t s, input logic x);
    det_t n;
    case (s)
      D0:      n = x ? D1 : D0;
      D1:      n = x ? D1 : D2;
      D2:      n = x ? D3 : D0;
      D3:      n = x ? D1 : D2;
      default: n = D0;
    endcase
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_comb begin
    ctl_d    = ctl_q;
    det_d    = det_q;
    sreg_d   = sreg_q;
    last_d   = last_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    match    = 1'b0;
    det_step = det_next(det_q, sreg_q[W-1]);
    case (ctl_q)
      IDLE: begin
        if (in_valid) begin
          ctl_d  = SHIFT;
          sreg_d = in_data;
          last_d = in_last;
          bit_d  = '0;
        end
      end
      SHIFT: begin
        det_d  = det_step;
        match  = (det_step == D3);
        if (match) cnt_d = sat_inc(cnt_q);
        sreg_d = {sreg_q[W-2:0], 1'b0};
        bit_d  = bit_q + 1'b1;
        if (bit_q == LAST_BIT) ctl_d = last_q ? REPORT : IDLE;
      end
      REPORT: begin
        if (out_ready) begin
          ctl_d = IDLE;
          cnt_d = '0;
`ifdef SEQ101_FRAME_RESYNC_EN
          det_d = D0;
`endif
        end
      end
      default: ctl_d = IDLE;
    endcase
  end

  // control state: async clear discards any partial frame
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ctl_q   <= IDLE;
      det_q   <= D0;
      last_q  <= 1'b0;
      bit_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      ctl_q   <= ctl_d;
      det_q   <= det_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      pulse_q <= match;
    end
  end

  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

  assign in_ready  = (ctl_q == IDLE);
  assign out_valid = (ctl_q == REPORT);
  assign out_count = cnt_q;
  assign det_pulse = pulse_q;

endmodule

// File: tb/tb_seq101_frame_scanner.sv
// Scoreboard bench for seq101_frame_scanner: a bit-window "101" model predicts per-frame counts and pulses.
module tb_seq101_frame_scanner;
  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, det_pulse, out_valid;
  logic [CNT_W-1:0] out_count;

  always #5 clk = ~clk;

  seq101_frame_scanner #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .det_pulse(det_pulse), .out_valid(out_valid),
    .out_count(out_count), .out_ready(out_ready)
  );

  typedef struct { int count; int pulses; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0;
  int pulse_cnt = 0;
  int rdy_mode = 1;
  // reference: last two serial bits seen since reset (or resync) and matches in current frame
  int hist_n = 0, h1 = 0, h2 = 0, frame_m = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic model_word(input logic [W-1:0] d, input logic last);
    for (int i = W - 1; i >= 0; i--) begin
      int x;
      x = int'(d[i]);
      if (hist_n >= 2 && h2 == 1 && h1 == 0 && x == 1) frame_m++;
      h2 = h1;
      h1 = x;
      if (hist_n < 2) hist_n++;
    end
    if (last) begin
      exp_t e;
      e.count  = (frame_m > MAXC) ? MAXC : frame_m;
      e.pulses = frame_m;
      sb.push_back(e);
      frame_m = 0;
`ifdef SEQ101_FRAME_RESYNC_EN
      hist_n = 0;
`endif
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      model_word(d, last);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // downstream ready, changed just after each rising edge
  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: counts pulses and checks each result at its handshake
  always @(negedge clk) begin
    if (clr) begin
      if (det_pulse) pulse_cnt++;
      if (out_valid && out_ready) begin
        exp_t e;
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_count", int'(out_count), e.count);
          check("det_pulses", pulse_cnt, e.pulses);
        end
        pulse_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int cnt0;
    logic [W-1:0] d;
    logic         l;

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_det_pulse", int'(det_pulse), 0);
    @(negedge clk);
    clr = 1'b1;
    rdy_mode = 1;

    send_word(8'hAA, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy_in_ready", int'(in_ready), 0);
    end
    drain();

    send_word(8'h02, 1'b0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy_in_ready_w1", int'(in_ready), 0);
    end
    @(negedge clk);
    check("ready_after_word", int'(in_ready), 1);
    send_word(8'h80, 1'b1);
    drain();

    send_word(8'h02, 1'b1);
    drain();
    send_word(8'h80, 1'b1);
    drain();

    for (int i = 0; i < 8; i++) send_word(8'hAA, 1'(i == 7));
    drain();

    rdy_mode = 0;
    @(posedge clk);
    #3;
    send_word(8'hAA, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("report_reached", int'(out_valid), 1);
    cnt0 = int'(out_count);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_count", int'(out_count), cnt0);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    send_word(8'hA5, 1'b0);
    repeat (4) @(posedge clk);
    #1 clr = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_count", int'(out_count), 0);
    check("mid_rst_det_pulse", int'(det_pulse), 0);
    hist_n = 0;
    frame_m = 0;
    pulse_cnt = 0;
    @(negedge clk);
    clr = 1'b1;
    send_word(8'h05, 1'b1);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = W'($urandom);
      l = 1'(($urandom_range(0, 3) == 0) || (i == 59));
      send_word(d, l);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
